// File: rtl/pwarb_pkg.sv
// Shared types and the rotating-priority search used by the pulse-wire
// arbiters. rr_pick works on a PWARB_MAX_N-wide vector; callers zero-extend
// their request vector and pass their real requester count in n.
package pwarb_pkg;

    localparam int PWARB_MAX_N = 16;
    localparam int PWARB_IDX_W = $clog2(PWARB_MAX_N);

    typedef logic [PWARB_IDX_W-1:0] idx_t;
    typedef logic [7:0]             burst_t;
    typedef logic [PWARB_MAX_N-1:0] vec_t;

    // Result of one rotating search: one-hot winner and whether any bit won.
    typedef struct packed {
        vec_t onehot;
        logic found;
    } pick_t;

    // What the arbiter does this cycle; kept as a named signal for probing.
    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_CONT = 2'd1,
        ACT_NEW  = 2'd2
    } act_e;

    // First set bit of req searching ptr, ptr+1, ... wrapping at n-1.
    // ptr is expected to be below n.
    function automatic pick_t rr_pick(vec_t req, idx_t ptr, int n = PWARB_MAX_N);
        pick_t r;
        int    idx;
        r = '0;
        for (int k = 0; k < PWARB_MAX_N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !r.found && req[idx_t'(idx)]) begin
                r.onehot[idx_t'(idx)] = 1'b1;
                r.found               = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pwarb_rr_pick.sv
// Purely combinational rotating-priority search over N requesters.
module pwarb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic                 found
);
    import pwarb_pkg::*;

    vec_t  req_ext;
    pick_t pick;

    // Widen the request vector to the package width and run the search.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        pick             = rr_pick(req_ext, idx_t'(ptr), N);
    end

    assign onehot = pick.onehot[N-1:0];
    assign found  = pick.found;

endmodule

// File: rtl/pulse_wire_arbiter.sv
// Round-robin arbiter sharing one pulse wire among N requesters, with bounded
// bursts: an owner keeps the wire for up to MAX_BURST consecutive cycles.
// Optional grant statistics are built when PULSE_WIRE_ARBITER_STATS_EN is
// defined; otherwise the STAT_* ports and counters do not exist.
module pulse_wire_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GRANT,
    output logic                 WSET,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 OWNER_VLD
`ifdef PULSE_WIRE_ARBITER_STATS_EN
    ,
    input  logic [$clog2(N)-1:0] STAT_SEL,
    output logic [CNT_W-1:0]     STAT_CNT,
    input  logic                 STAT_CLR
`endif
);
    import pwarb_pkg::*;

    localparam int             IW         = $clog2(N);
    localparam burst_t         BURST_LAST = burst_t'(MAX_BURST - 1);
    localparam logic [N-1:0]   ONE_HOT0   = N'(1);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(N - 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic          owner_vld;
    burst_t        burst_cnt;

    logic [N-1:0]  pick_onehot;
    logic          pick_found;
    logic [IW-1:0] new_idx;
    act_e          act;

    pwarb_rr_pick #(.N(N)) u_pick (
        .req    (REQ),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .found  (pick_found)
    );

    // Choose continue / new grant / nothing; reset forces the grant low at once.
    always_comb begin
        act     = ACT_NONE;
        GRANT   = '0;
        new_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_onehot[i]) begin
                new_idx = IW'(i);
            end
        end
        if (!RST && EN) begin
            if (owner_vld && REQ[owner] && (burst_cnt < BURST_LAST)) begin
                act   = ACT_CONT;
                GRANT = ONE_HOT0 << owner;
            end else if (pick_found) begin
                act   = ACT_NEW;
                GRANT = pick_onehot;
            end
        end
    end

    // Burst, owner and priority-pointer update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (act)
                ACT_CONT: begin
                    burst_cnt <= burst_cnt + 8'd1;
                end
                ACT_NEW: begin
                    owner     <= new_idx;
                    owner_vld <= 1'b1;
                    burst_cnt <= '0;
                    ptr       <= (new_idx == LAST_IDX) ? '0 : new_idx + IW'(1);
                end
                default: begin
                    owner_vld <= 1'b0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    assign WSET      = |GRANT;
    assign OWNER     = owner;
    assign OWNER_VLD = owner_vld;

    // The wire must see at most one fire per cycle.
    a_onehot_grant: assert property (@(posedge CLK) disable iff (RST)
        $onehot0(GRANT) && (WSET == |GRANT));

`ifdef PULSE_WIRE_ARBITER_STATS_EN
    logic [CNT_W-1:0] stat_cnt [N];

    // Saturating per-requester grant counters; clear wins over increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (STAT_CLR) begin
            for (int i = 0; i < N; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (GRANT[i] && (stat_cnt[i] != '1)) begin
                    stat_cnt[i] <= stat_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign STAT_CNT = stat_cnt[STAT_SEL];
`endif

endmodule

// File: tb/tb_pulse_wire_arbiter.sv
// Bench for pulse_wire_arbiter: hand-derived vector tables for the directed
// sequences, a second instance with MAX_BURST=1, randomized traffic against a
// reference model, and the statistics counters when that build is selected.
module tb_pulse_wire_arbiter;

    localparam int N   = 4;
    localparam int MB0 = 2;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] REQ;
    logic [3:0] REQ1;
    logic [1:0] stat_sel;
    logic       stat_clr;

    logic [3:0] grant0, grant1;
    logic       wset0, wset1;
    logic [1:0] owner0, owner1;
    logic       vld0, vld1;
    logic [3:0] stat_cnt0, stat_cnt1;

    always #5 CLK = ~CLK;

    pulse_wire_arbiter #(.N(N), .MAX_BURST(MB0), .CNT_W(4)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .REQ       (REQ),
        .GRANT     (grant0),
        .WSET      (wset0),
        .OWNER     (owner0),
        .OWNER_VLD (vld0)
`ifdef PULSE_WIRE_ARBITER_STATS_EN
        ,
        .STAT_SEL  (stat_sel),
        .STAT_CNT  (stat_cnt0),
        .STAT_CLR  (stat_clr)
`endif
    );

    pulse_wire_arbiter #(.N(N), .MAX_BURST(1), .CNT_W(4)) u_dut1 (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .REQ       (REQ1),
        .GRANT     (grant1),
        .WSET      (wset1),
        .OWNER     (owner1),
        .OWNER_VLD (vld1)
`ifdef PULSE_WIRE_ARBITER_STATS_EN
        ,
        .STAT_SEL  (stat_sel),
        .STAT_CNT  (stat_cnt1),
        .STAT_CLR  (stat_clr)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instance u_dut) ----------------
    // Tracks the owner, how many grants it has had in a row, and the index
    // the next search starts from.
    int m_ptr, m_owner, m_run;
    bit m_vld;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_run = 0; m_vld = 0;
    endtask

    // Compare u_dut outputs with the model for the current inputs, then
    // advance the model as the next rising edge will.
    task automatic sample_and_step();
        int         pick;
        bit         cont;
        logic [3:0] eg;
        pick = -1;
        cont = 0;
        if (EN) begin
            cont = m_vld && REQ[m_owner] && (m_run < MB0);
            if (cont) begin
                pick = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && REQ[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                end
            end
        end
        eg = (pick < 0) ? 4'b0000 : 4'(1 << pick);
        check("model_grant", grant0, eg);
        check("model_wset", wset0, |eg);
        check("model_vld", vld0, m_vld);
        if (m_vld) check("model_owner", owner0, m_owner);
        if (pick < 0) begin
            m_vld = 0; m_run = 0;
        end else if (cont) begin
            m_run++;
        end else begin
            m_owner = pick; m_vld = 1; m_run = 1; m_ptr = (pick + 1) % N;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; EN = 1'b1; REQ = 4'b1111; REQ1 = 4'b1111; stat_clr = 1'b0;
        #1;
        check("rst_grant", grant0, 4'b0000);
        check("rst_wset", wset0, 1'b0);
        check("rst_vld", vld0, 1'b0);
        check("rst_owner", owner0, 2'd0);
        check("rst_grant1", grant1, 4'b0000);
        @(negedge CLK);
        EN = 1'b0; REQ = '0; REQ1 = '0;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic en, input logic [3:0] req, input logic [3:0] req1);
        @(negedge CLK);
        EN = en; REQ = req; REQ1 = req1;
        #1;
        sample_and_step();
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
        logic       vld;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic [3:0] req, logic [3:0] grant, logic vld);
        vec_t v;
        v.en = en; v.req = req; v.grant = grant; v.vld = vld;
        return v;
    endfunction

    task automatic run_table(input string name);
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].req, 4'b0000);
            check({name, "_grant"}, grant0, tbl[i].grant);
            check({name, "_wset"}, wset0, |tbl[i].grant);
            check({name, "_vld"}, vld0, tbl[i].vld);
        end
        tbl.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        RST = 1'b0; EN = 1'b0; REQ = '0; REQ1 = '0; stat_sel = 2'd2; stat_clr = 1'b0;
        model_reset();

        // All requesting: 0,0,1,1,2,2,3,3,0.
        tbl.push_back(mk(1, 4'b1111, 4'b0001, 0));
        tbl.push_back(mk(1, 4'b1111, 4'b0001, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0010, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0010, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0100, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0100, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b1000, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b1000, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0001, 1));
        run_table("allreq");

        // Owner 1 drops mid-burst: 3 wins that cycle, then ptr=0 picks 0.
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 0));
        tbl.push_back(mk(1, 4'b1001, 4'b1000, 1));
        tbl.push_back(mk(1, 4'b1001, 4'b1000, 1));
        tbl.push_back(mk(1, 4'b1001, 4'b0001, 1));
        run_table("drop");

        // Wrap-around from ptr=3 with REQ=0011, then ptr=1.
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 0));
        tbl.push_back(mk(1, 4'b0011, 4'b0001, 1));
        tbl.push_back(mk(1, 4'b0011, 4'b0001, 1));
        tbl.push_back(mk(1, 4'b0011, 4'b0010, 1));
        run_table("wrap");

        // EN low mid-burst: no grant, burst ends, ptr stays at 2.
        tbl.push_back(mk(1, 4'b0010, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1));
        tbl.push_back(mk(1, 4'b0110, 4'b0100, 0));
        run_table("en_low");

        // Reset pulsed between edges mid-burst.
        do_reset();
        step(1, 4'b1111, 4'b0000);
        step(1, 4'b1111, 4'b0000);
        step(1, 4'b1111, 4'b0000);
        step(1, 4'b1111, 4'b0000);
        check("rstmid_pre_grant", grant0, 4'b0010);
        #1 RST = 1'b1;
        #1;
        check("rstmid_grant", grant0, 4'b0000);
        check("rstmid_vld", vld0, 1'b0);
        check("rstmid_wset", wset0, 1'b0);
        RST = 1'b0;
        model_reset();
        #1;
        sample_and_step();
        check("rstmid_ptr0", grant0, 4'b0001);

        // Single requester on the MAX_BURST=1 instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0000, 4'b0100);
            check("single_grant", grant1, 4'b0100);
            check("single_vld", vld1, (i == 0) ? 1'b0 : 1'b1);
            if (i > 0) check("single_owner", owner1, 2'd2);
        end
        step(1, 4'b0000, 4'b1100);
        check("single_ptr3", grant1, 4'b1000);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), 4'b0000);
        end

`ifdef PULSE_WIRE_ARBITER_STATS_EN
        // Requester 2 granted every cycle; 4-bit counter saturates at 15.
        do_reset();
        stat_sel = 2'd2;
        for (int i = 0; i < 20; i++) begin
            step(1, 4'b0100, 4'b0000);
            if (i == 5) check("stat_count5", stat_cnt0, 4'd5);
            if (i == 19) check("stat_sat", stat_cnt0, 4'd15);
        end
        @(negedge CLK);
        stat_clr = 1'b1;
        #1;
        sample_and_step();
        check("stat_hold", stat_cnt0, 4'd15);
        @(negedge CLK);
        stat_clr = 1'b0;
        #1;
        sample_and_step();
        check("stat_clr_wins", stat_cnt0, 4'd0);
        stat_sel = 2'd0;
        #1;
        check("stat_other", stat_cnt0, 4'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
